// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and helpers for the SPI command arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] addr;
        logic [15:0] len;
        logic        op;
    } desc_t;

    // Total bits on the wire: opcode + address + payload, clamped to 16 bits.
    function automatic logic [15:0] calc_bit_len(input logic [15:0] payload,
                                                 input int          addr_bytes);
        logic [19:0] w_total;
        w_total = 20'd8 * (20'd1 + 20'(addr_bytes) + {4'd0, payload});
        return (w_total > 20'h0FFFF) ? 16'hFFFF : w_total[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_arbiter_if
//  Purpose  : Requester, SPI engine and TX FIFO signals of the command arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_cmd_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DATA = 8
) ();

    logic [NREQ-1:0]         req;
    logic [NREQ*8-1:0]       cmd_opcode;
    logic [NREQ*32-1:0]      cmd_addr;
    logic [NREQ*16-1:0]      cmd_len;
    logic [NREQ-1:0]         cmd_op;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         done;
    logic                    err;
    logic                    grant_valid;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic [15:0]             len;
    logic                    op;
    logic                    work;
    logic                    busy;
    logic [DATA-1:0]         wdata;
    logic                    wr;
    logic                    full;

    modport slave (
        input  req, cmd_opcode, cmd_addr, cmd_len, cmd_op, busy, full,
        output ack, done, err, grant_valid, grant_id, len, op, work, wdata, wr
    );

    modport master (
        output req, cmd_opcode, cmd_addr, cmd_len, cmd_op, busy, full,
        input  ack, done, err, grant_valid, grant_id, len, op, work, wdata, wr
    );

endinterface
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rr_arbiter
//  Purpose  : Combinational round-robin pick; search starts just after i_rr_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDW-1:0]  i_rr_ptr,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_idx,
    output logic                 o_any
);

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    int              w_sel;
    int              w_pos;

    always_comb begin
        // Rotate so bit 0 is the requester right after the last winner.
        w_rot   = NREQ'({i_req, i_req} >> (int'(i_rr_ptr) + 1));
        w_found = 1'b0;
        w_sel   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sel   = i;
            end
        end
        w_pos = int'(i_rr_ptr) + 1 + w_sel;
        if (w_pos >= NREQ) begin
            w_pos = w_pos - NREQ;
        end
        o_any   = |i_req;
        o_idx   = IDW'(w_pos);
        o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_arbiter
//  Purpose  : Round-robin sharing of one SPI engine and TX FIFO between NREQ
//             command requesters; pushes the header and starts the engine.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA       = 8,
    parameter int ADDR_BYTES = 3,
    parameter int BUSY_TO    = 15
) (
    input  wire logic           clk,
    input  wire logic           rst,
    spi_cmd_arbiter_if.slave    bus
);

    localparam int         c_IDW       = $clog2(NREQ);
    localparam int         c_TOW       = $clog2(BUSY_TO + 1);
    localparam logic [2:0] c_IDX_START = 3'(ADDR_BYTES);

    state_t              r_state;
    desc_t               r_desc;
    logic [c_IDW-1:0]    r_rr_ptr;
    logic [c_IDW-1:0]    r_id;
    logic [2:0]          r_idx;
    logic [c_TOW-1:0]    r_to_cnt;

    logic [NREQ-1:0]     r_ack;
    logic [NREQ-1:0]     r_done;
    logic                r_err;
    logic                r_grant_valid;
    logic [15:0]         r_len;
    logic                r_op;
    logic                r_work;
    logic [DATA-1:0]     r_wdata;
    logic                r_wr;

    logic [NREQ-1:0]     w_grant;
    logic [c_IDW-1:0]    w_grant_idx;
    logic                w_grant_any;
    logic [7:0]          w_hdr_byte;

    logic [7:0]          w_opc  [NREQ];
    logic [31:0]         w_addr [NREQ];
    logic [15:0]         w_len  [NREQ];
    logic                w_op   [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_opc[gi]  = bus.cmd_opcode[8*gi +: 8];
        assign w_addr[gi] = bus.cmd_addr[32*gi +: 32];
        assign w_len[gi]  = bus.cmd_len[16*gi +: 16];
        assign w_op[gi]   = bus.cmd_op[gi];
    end

    spi_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (c_IDW)
    ) u_rr (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_grant_idx),
        .o_any    (w_grant_any)
    );

    // Top index is the opcode; lower indices walk the address down to byte 0.
    always_comb begin
        w_hdr_byte = r_desc.addr[{r_idx[1:0], 3'b000} +: 8];
        if (r_idx == c_IDX_START) begin
            w_hdr_byte = r_desc.opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_desc        <= '0;
            r_rr_ptr      <= c_IDW'(NREQ - 1);
            r_id          <= '0;
            r_idx         <= '0;
            r_to_cnt      <= '0;
            r_ack         <= '0;
            r_done        <= '0;
            r_err         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_len         <= '0;
            r_op          <= 1'b0;
            r_work        <= 1'b0;
            r_wdata       <= '0;
            r_wr          <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            r_work <= 1'b0;
            r_wr   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!bus.busy && w_grant_any) begin
                        r_desc        <= '{opcode: w_opc[w_grant_idx],
                                           addr:   w_addr[w_grant_idx],
                                           len:    w_len[w_grant_idx],
                                           op:     w_op[w_grant_idx]};
                        r_ack         <= w_grant;
                        r_id          <= w_grant_idx;
                        r_grant_valid <= 1'b1;
                        r_rr_ptr      <= w_grant_idx;
                        r_idx         <= c_IDX_START;
                        r_state       <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (!bus.full) begin
                        r_wr    <= 1'b1;
                        r_wdata <= DATA'(w_hdr_byte);
                        if (r_idx == 3'd0) begin
                            r_state <= ST_START;
                        end else begin
                            r_idx <= r_idx - 3'd1;
                        end
                    end
                end

                ST_START: begin
                    r_work   <= 1'b1;
                    r_op     <= r_desc.op;
                    r_len    <= calc_bit_len(r_desc.len, ADDR_BYTES);
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    // Done lands exactly BUSY_TO cycles after the work pulse.
                    if (bus.busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_to_cnt == c_TOW'(BUSY_TO - 1)) begin
                        r_done        <= NREQ'(1) << r_id;
                        r_err         <= 1'b1;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!bus.busy) begin
                        r_done        <= NREQ'(1) << r_id;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_id;
    assign bus.len         = r_len;
    assign bus.op          = r_op;
    assign bus.work        = r_work;
    assign bus.wdata       = r_wdata;
    assign bus.wr          = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cmd_arbiter
//  Purpose  : Scoreboard bench for spi_cmd_arbiter with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_arbiter;

    localparam int NREQ    = 2;
    localparam int DATA    = 8;
    localparam int AB      = 3;
    localparam int BUSY_TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_cmd_arbiter_if #(.NREQ(NREQ), .DATA(DATA)) bus ();

    spi_cmd_arbiter #(
        .NREQ(NREQ), .DATA(DATA), .ADDR_BYTES(AB), .BUSY_TO(BUSY_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  d_opc  [NREQ];
    logic [31:0] d_addr [NREQ];
    logic [15:0] d_len  [NREQ];
    logic        d_op   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.cmd_opcode[8*g +: 8]   = d_opc[g];
        assign bus.cmd_addr[32*g +: 32]   = d_addr[g];
        assign bus.cmd_len[16*g +: 16]    = d_len[g];
        assign bus.cmd_op[g]              = d_op[g];
    end

    // Expected-event queues filled by the model, drained by the monitor.
    int ack_q[$];
    int byte_q[$];
    int work_q[$];
    int done_q[$];
    int last_w;
    int work_cyc;
    int full_mode;
    int m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Round-robin reference: next pending requester after the previous winner.
    function automatic int predict(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int k;
            k = (last_w + i) % NREQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic push_expect(input int w, input bit to);
        int l;
        ack_q.push_back(w);
        byte_q.push_back(int'(d_opc[w]));
        for (int k = AB - 1; k >= 0; k--) begin
            byte_q.push_back(int'((d_addr[w] >> (8 * k)) & 32'hFF));
        end
        l = 8 * (1 + AB + int'(d_len[w]));
        if (l > 65535) l = 65535;
        work_q.push_back(l * 2 + int'(d_op[w]));
        done_q.push_back(w * 2 + int'(to));
        last_w = w;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack != '0) begin
                if (ack_q.size() == 0) flag("unexpected ack");
                else begin
                    m_e = ack_q.pop_front();
                    check("ack", 64'(bus.ack), 64'(1 << m_e));
                    check("grant_id", 64'(bus.grant_id), 64'(m_e));
                    check("grant_valid_on_ack", 64'(bus.grant_valid), 64'd1);
                end
            end
            if (bus.wr) begin
                if (byte_q.size() == 0) flag("unexpected wr");
                else check("wdata", 64'(bus.wdata), 64'(byte_q.pop_front()));
            end
            if (bus.work) begin
                work_cyc = cyc;
                if (work_q.size() == 0) flag("unexpected work");
                else check("work_len_op", 64'({bus.len, bus.op}), 64'(work_q.pop_front()));
            end
            if (bus.done != '0) begin
                if (done_q.size() == 0) flag("unexpected done");
                else begin
                    m_e = done_q.pop_front();
                    check("done", 64'(bus.done), 64'(1 << (m_e / 2)));
                    check("err", 64'(bus.err), 64'(m_e % 2));
                    check("grant_valid_cleared", 64'(bus.grant_valid), 64'd0);
                    if (m_e % 2 == 1) check("timeout_latency", 64'(cyc - work_cyc), 64'(BUSY_TO));
                end
            end else if (bus.err) begin
                flag("err without done");
            end
        end
    end

    always @(negedge clk) begin
        if (full_mode == 0) bus.full = 1'b0;
        else if (full_mode == 1) bus.full = ($urandom_range(0, 3) == 0);
    end

    task automatic rand_desc(input int i);
        d_opc[i]  = 8'($urandom);
        d_addr[i] = $urandom;
        d_len[i]  = ($urandom_range(0, 6) == 0) ? 16'($urandom_range(65000, 65535))
                                                 : 16'($urandom_range(0, 40));
        d_op[i]   = 1'($urandom);
    endtask

    task automatic wait_ack(output int w);
        w = -1;
        for (int t = 0; t < 60 && w < 0; t++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) w = i;
        end
        if (w < 0) flag("ack timeout");
    endtask

    task automatic wait_wr(input int n);
        int seen;
        seen = 0;
        for (int t = 0; t < 60 && seen < n; t++) begin
            @(negedge clk);
            if (bus.wr) seen++;
        end
        if (seen < n) flag("wr timeout");
    endtask

    task automatic engine(input bit to, input int bdelay, input int blen);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = bus.work;
        end
        if (!got) flag("work timeout");
        if (!to) begin
            repeat (bdelay) @(negedge clk);
            bus.busy = 1'b1;
            repeat (blen) @(negedge clk);
            bus.busy = 1'b0;
            @(negedge clk);
            check("done_after_busy_fall", 64'(bus.done != '0), 64'd1);
        end else begin
            got = 1'b0;
            for (int t = 0; t < BUSY_TO + 5 && !got; t++) begin
                @(negedge clk);
                got = (bus.done != '0);
            end
            if (!got) flag("timeout done missing");
        end
        #1;
        check("queues_drained", 64'(ack_q.size() + byte_q.size() + work_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic random_txn(input bit last);
        int w;
        bit to;
        if (bus.req == '0) begin
            for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) begin
                rand_desc(i);
                bus.req[i] = 1'b1;
            end
            if (bus.req == '0) begin
                rand_desc(0);
                bus.req[0] = 1'b1;
            end
        end
        to = ($urandom_range(0, 5) == 0);
        push_expect(predict(bus.req), to);
        wait_ack(w);
        if (w >= 0) bus.req[w] = 1'b0;
        if (last) bus.req = '0;
        else begin
            for (int i = 0; i < NREQ; i++) if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
                rand_desc(i);
                bus.req[i] = 1'b1;
            end
        end
        engine(to, $urandom_range(0, 3), $urandom_range(1, 8));
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.ack, bus.done, bus.err, bus.grant_valid, bus.grant_id,
                    bus.len, bus.op, bus.work, bus.wdata, bus.wr});
    endfunction

    initial begin
        int w;
        bus.req = '0; bus.busy = 1'b0; bus.full = 1'b0;
        full_mode = 0; last_w = NREQ - 1; work_cyc = 0;
        for (int i = 0; i < NREQ; i++) rand_desc(i);
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;

        // Single request with the reference descriptor
        d_opc[0] = 8'h03; d_addr[0] = 32'h0000_1900; d_len[0] = 16'd2; d_op[0] = 1'b0;
        bus.req = 2'b01;
        push_expect(predict(bus.req), 1'b0);
        wait_ack(w);
        bus.req = '0;
        engine(1'b0, 1, 10);

        // Round robin with both requests held
        bus.req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            push_expect(predict(bus.req), 1'b0);
            wait_ack(w);
            if (n == 3) bus.req = '0;
            engine(1'b0, $urandom_range(0, 3), $urandom_range(1, 5));
        end

        // FIFO backpressure after the second header byte
        full_mode = 3;
        bus.full = 1'b0;
        rand_desc(0);
        bus.req = 2'b01;
        push_expect(predict(bus.req), 1'b0);
        wait_ack(w);
        bus.req = '0;
        wait_wr(2);
        bus.full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("wr_held_off", 64'(bus.wr), 64'd0);
        end
        bus.full = 1'b0;
        engine(1'b0, 2, 3);
        full_mode = 0;

        // Engine never goes busy
        rand_desc(1);
        bus.req = 2'b10;
        push_expect(predict(bus.req), 1'b1);
        wait_ack(w);
        bus.req = '0;
        engine(1'b1, 0, 0);

        // Length saturation
        rand_desc(0);
        d_len[0] = 16'hFFFF;
        bus.req = 2'b01;
        push_expect(predict(bus.req), 1'b0);
        wait_ack(w);
        bus.req = '0;
        engine(1'b0, 0, 2);

        // No grant while the engine is busy
        bus.busy = 1'b1;
        rand_desc(1);
        bus.req = 2'b10;
        repeat (5) begin
            @(negedge clk);
            check("no_grant_while_busy", 64'(bus.grant_valid), 64'd0);
        end
        push_expect(predict(bus.req), 1'b0);
        bus.busy = 1'b0;
        wait_ack(w);
        bus.req = '0;
        engine(1'b0, 1, 4);

        // Reset in the middle of the header
        rand_desc(0);
        bus.req = 2'b01;
        push_expect(predict(bus.req), 1'b0);
        wait_ack(w);
        bus.req = '0;
        wait_wr(2);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_header_outputs", outs(), 64'd0);
        ack_q.delete(); byte_q.delete(); work_q.delete(); done_q.delete();
        last_w = NREQ - 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_done_after_reset", 64'(bus.done), 64'd0);
        end
        rand_desc(0);
        bus.req = 2'b01;
        push_expect(predict(bus.req), 1'b0);
        wait_ack(w);
        bus.req = '0;
        engine(1'b0, 0, 3);

        // Randomized traffic with random FIFO backpressure
        full_mode = 1;
        for (int n = 0; n < 40; n++) random_txn(n == 39);
        full_mode = 0;

        repeat (5) @(negedge clk);
        check("final_queues_empty", 64'(ack_q.size() + byte_q.size() + work_q.size() + done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
